multicycle_control_fsm_cpu: RTL and testbench

Multi-cycle sequencer for the CPU datapath. It replaces the single-cycle combinational control path with a state machine that drives one shared memory port. Each instruction is stepped through FETCH, DECODE, EXEC, MEM and WB, with a ready handshake and a wait-timeout fault. The block emits the same datapath controls (type flags, ALU opcode, PC mux select, register/memory write enables) plus fetch, IR and PC strobes.

---
 rtl/multicycle_control_fsm_cpu.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control_fsm_cpu.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_cpu.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// over one shared memory port, with a ready handshake and a sticky wait-timeout fault.
module multicycle_control_fsm_cpu #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       is_alu_zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       is_data_access,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] control_mux_for_PC,
   output logic       is_R_type,
   output logic       is_I_type,
   output logic       is_J_type,
   output logic       is_write_from_mem,
   output logic       is_write_reg,
   output logic [5:0] opcode_alu,
   output logic       illegal_op,
   output logic       bus_error,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      ERR    = 3'd7
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_NOP   = 6'b111111;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] ALU_ADD  = 6'b100000;
   localparam logic [5:0] ALU_SUB  = 6'b100010;
   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   state_t     cur, nxt;
   logic [7:0] wait_cnt;
   logic       op_r, op_addi, op_lw, op_sw, op_beq, op_j, op_nop;
   logic       r_add, r_sub, op_legal;
   logic       waiting, wait_timeout;

   always_comb begin
      op_r     = (opcode == OP_RTYPE);
      op_addi  = (opcode == OP_ADDI);
      op_lw    = (opcode == OP_LW);
      op_sw    = (opcode == OP_SW);
      op_beq   = (opcode == OP_BEQ);
      op_j     = (opcode == OP_J);
      op_nop   = (opcode == OP_NOP);
      r_add    = op_r && (funct == FN_ADD);
      r_sub    = op_r && (funct == FN_SUB);
      op_legal = r_add || r_sub || op_addi || op_lw || op_sw || op_beq || op_j || op_nop;
   end

   // Counter runs only while a memory access is stalled; any other cycle clears it,
   // which covers the clear-on-entry to FETCH and MEM.
   assign waiting      = ((cur == FETCH) || (cur == MEM)) && !mem_ready;
   assign wait_timeout = waiting && (wait_cnt == WAIT_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         cur      <= FETCH;
         wait_cnt <= '0;
      end else begin
         cur      <= nxt;
         wait_cnt <= waiting ? wait_cnt + 8'd1 : '0;
      end
   end

   always_comb begin
      nxt = cur;
      case (cur)
         FETCH: begin
            if (mem_ready)         nxt = DECODE;
            else if (wait_timeout) nxt = ERR;
         end
         DECODE: begin
            if (!op_legal || op_nop || op_j) nxt = FETCH;
            else                             nxt = EXEC;
         end
         EXEC: begin
            if (op_lw || op_sw) nxt = MEM;
            else if (op_beq)    nxt = FETCH;
            else                nxt = WB;
         end
         MEM: begin
            if (mem_ready)         nxt = op_lw ? WB : FETCH;
            else if (wait_timeout) nxt = ERR;
         end
         WB:      nxt = FETCH;
         ERR:     nxt = ERR;
         default: nxt = FETCH;
      endcase
   end

   always_comb begin
      mem_req            = 1'b0;
      mem_we             = 1'b0;
      is_data_access     = 1'b0;
      ir_write           = 1'b0;
      pc_write           = 1'b0;
      control_mux_for_PC = 2'b00;
      is_R_type          = 1'b0;
      is_I_type          = 1'b0;
      is_J_type          = 1'b0;
      is_write_from_mem  = 1'b0;
      is_write_reg       = 1'b0;
      opcode_alu         = 6'b000000;
      illegal_op         = 1'b0;
      bus_error          = 1'b0;

      if (cur inside {DECODE, EXEC, MEM, WB}) begin
         is_R_type = op_r;
         is_I_type = op_addi || op_lw || op_sw || op_beq;
         is_J_type = op_j;
      end

      case (cur)
         FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
         end
         DECODE: begin
            if (!op_legal) begin
               illegal_op = 1'b1;
               pc_write   = 1'b1;
            end else if (op_nop) begin
               pc_write = 1'b1;
            end else if (op_j) begin
               pc_write           = 1'b1;
               control_mux_for_PC = 2'b10;
            end
         end
         EXEC: begin
            opcode_alu = (r_sub || op_beq) ? ALU_SUB : ALU_ADD;
            if (op_beq) begin
               pc_write           = 1'b1;
               control_mux_for_PC = is_alu_zero ? 2'b01 : 2'b00;
            end
         end
         MEM: begin
            mem_req        = 1'b1;
            is_data_access = 1'b1;
            mem_we         = op_sw;
            pc_write       = op_sw && mem_ready;
         end
         WB: begin
            is_write_reg      = 1'b1;
            is_write_from_mem = op_lw;
            pc_write          = 1'b1;
         end
         ERR:     bus_error = 1'b1;
         default: ;
      endcase

      // Reset masks every strobe so an aborted instruction leaves no PC/register/memory trace.
      if (rst) begin
         mem_req      = 1'b0;
         mem_we       = 1'b0;
         ir_write     = 1'b0;
         pc_write     = 1'b0;
         is_write_reg = 1'b0;
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_multicycle_control_fsm_cpu.sv
// Scoreboard bench for multicycle_control_fsm_cpu: per-cycle expected outputs are queued
// when inputs are driven and compared against the DUT on the falling edge.
module tb_multicycle_control_fsm_cpu;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_NOP  = 6'b111111;
   localparam logic [5:0] OP_BAD  = 6'b010101;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_BAD  = 6'b000001;
   localparam logic [5:0] A_NONE  = 6'b000000;
   localparam logic [5:0] A_ADD   = 6'b100000;
   localparam logic [5:0] A_SUB   = 6'b100010;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic       is_alu_zero, mem_ready;
   logic       mem_req, mem_we, is_data_access, ir_write, pc_write;
   logic [1:0] control_mux_for_PC;
   logic       is_R_type, is_I_type, is_J_type, is_write_from_mem, is_write_reg;
   logic [5:0] opcode_alu;
   logic       illegal_op, bus_error;
   logic [2:0] state;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   typedef struct packed {
      logic [2:0] st;
      logic [4:0] strb;  // {mem_req, mem_we, is_data_access, ir_write, pc_write}
      logic [1:0] mux;
      logic [2:0] rij;   // {is_R_type, is_I_type, is_J_type}
      logic [1:0] wr;    // {is_write_from_mem, is_write_reg}
      logic [5:0] alu;
      logic       ill;
      logic       berr;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   multicycle_control_fsm_cpu #(.MAX_WAIT(15)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
      .is_alu_zero(is_alu_zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .is_data_access(is_data_access),
      .ir_write(ir_write), .pc_write(pc_write), .control_mux_for_PC(control_mux_for_PC),
      .is_R_type(is_R_type), .is_I_type(is_I_type), .is_J_type(is_J_type),
      .is_write_from_mem(is_write_from_mem), .is_write_reg(is_write_reg),
      .opcode_alu(opcode_alu), .illegal_op(illegal_op), .bus_error(bus_error),
      .state(state)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] st, input logic [4:0] strb, input logic [1:0] mux,
                               input logic [2:0] rij, input logic [1:0] wr, input logic [5:0] alu,
                               input logic ill, input logic berr);
      exp_t e;
      e.st = st; e.strb = strb; e.mux = mux; e.rij = rij;
      e.wr = wr; e.alu = alu; e.ill = ill; e.berr = berr;
      return e;
   endfunction

   // Drive one cycle of inputs and queue what the DUT must show during that cycle.
   task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, input exp_t e);
      @(posedge clk);
      #1;
      rst = r; opcode = op; funct = fn; is_alu_zero = z; mem_ready = rdy;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("state",     8'(state), 8'(e.st));
         check("mem_req",   8'(mem_req), 8'(e.strb[4]));
         check("mem_we",    8'(mem_we), 8'(e.strb[3]));
         check("data_acc",  8'(is_data_access), 8'(e.strb[2]));
         check("ir_write",  8'(ir_write), 8'(e.strb[1]));
         check("pc_write",  8'(pc_write), 8'(e.strb[0]));
         check("pc_mux",    8'(control_mux_for_PC), 8'(e.mux));
         check("type_rij",  8'({is_R_type, is_I_type, is_J_type}), 8'(e.rij));
         check("wr_mem",    8'(is_write_from_mem), 8'(e.wr[1]));
         check("wr_reg",    8'(is_write_reg), 8'(e.wr[0]));
         check("alu_op",    8'(opcode_alu), 8'(e.alu));
         check("illegal",   8'(illegal_op), 8'(e.ill));
         check("bus_error", 8'(bus_error), 8'(e.berr));
      end
   end

   initial begin
      rst = 1'b1; opcode = OP_NOP; funct = '0; is_alu_zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk);
      // reset held: FETCH state with every strobe masked
      cyc(1, OP_NOP, '0, 0, 1, mk(3'd0, 5'b00000, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));

      // lw, zero wait: 0,1,2,3,4
      cyc(0, OP_LW, '0, 0, 1, mk(3'd0, 5'b10010, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_LW, '0, 0, 1, mk(3'd1, 5'b00000, 2'b00, 3'b010, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_LW, '0, 0, 1, mk(3'd2, 5'b00000, 2'b00, 3'b010, 2'b00, A_ADD, 0, 0));
      cyc(0, OP_LW, '0, 0, 1, mk(3'd3, 5'b10100, 2'b00, 3'b010, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_LW, '0, 0, 1, mk(3'd4, 5'b00001, 2'b00, 3'b010, 2'b11, A_NONE, 0, 0));

      // beq taken then not taken
      for (int i = 0; i < 2; i++) begin
         logic z;
         z = (i == 0);
         cyc(0, OP_BEQ, '0, z, 1, mk(3'd0, 5'b10010, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));
         cyc(0, OP_BEQ, '0, z, 1, mk(3'd1, 5'b00000, 2'b00, 3'b010, 2'b00, A_NONE, 0, 0));
         cyc(0, OP_BEQ, '0, z, 1, mk(3'd2, 5'b00001, z ? 2'b01 : 2'b00, 3'b010, 2'b00, A_SUB, 0, 0));
      end

      // fetch with 3 wait cycles, then nop retires from DECODE
      for (int i = 0; i < 3; i++)
         cyc(0, OP_NOP, '0, 0, 0, mk(3'd0, 5'b10000, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_NOP, '0, 0, 1, mk(3'd0, 5'b10010, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_NOP, '0, 0, 1, mk(3'd1, 5'b00001, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));

      // j
      cyc(0, OP_J, '0, 0, 1, mk(3'd0, 5'b10010, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_J, '0, 0, 1, mk(3'd1, 5'b00001, 2'b10, 3'b001, 2'b00, A_NONE, 0, 0));

      // R-type sub
      cyc(0, OP_R, FN_SUB, 0, 1, mk(3'd0, 5'b10010, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_R, FN_SUB, 0, 1, mk(3'd1, 5'b00000, 2'b00, 3'b100, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_R, FN_SUB, 0, 1, mk(3'd2, 5'b00000, 2'b00, 3'b100, 2'b00, A_SUB, 0, 0));
      cyc(0, OP_R, FN_SUB, 0, 1, mk(3'd4, 5'b00001, 2'b00, 3'b100, 2'b01, A_NONE, 0, 0));

      // sw with one memory wait cycle
      cyc(0, OP_SW, '0, 0, 1, mk(3'd0, 5'b10010, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_SW, '0, 0, 1, mk(3'd1, 5'b00000, 2'b00, 3'b010, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_SW, '0, 0, 1, mk(3'd2, 5'b00000, 2'b00, 3'b010, 2'b00, A_ADD, 0, 0));
      cyc(0, OP_SW, '0, 0, 0, mk(3'd3, 5'b11100, 2'b00, 3'b010, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_SW, '0, 0, 1, mk(3'd3, 5'b11101, 2'b00, 3'b010, 2'b00, A_NONE, 0, 0));

      // illegal opcode, then illegal R-type funct
      cyc(0, OP_BAD, '0, 0, 1, mk(3'd0, 5'b10010, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_BAD, '0, 0, 1, mk(3'd1, 5'b00001, 2'b00, 3'b000, 2'b00, A_NONE, 1, 0));
      cyc(0, OP_R, FN_BAD, 0, 1, mk(3'd0, 5'b10010, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_R, FN_BAD, 0, 1, mk(3'd1, 5'b00001, 2'b00, 3'b100, 2'b00, A_NONE, 1, 0));

      // reset during a stalled sw MEM cycle aborts it
      cyc(0, OP_SW, '0, 0, 1, mk(3'd0, 5'b10010, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_SW, '0, 0, 1, mk(3'd1, 5'b00000, 2'b00, 3'b010, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_SW, '0, 0, 1, mk(3'd2, 5'b00000, 2'b00, 3'b010, 2'b00, A_ADD, 0, 0));
      cyc(0, OP_SW, '0, 0, 0, mk(3'd3, 5'b11100, 2'b00, 3'b010, 2'b00, A_NONE, 0, 0));
      cyc(1, OP_SW, '0, 0, 0, mk(3'd3, 5'b00100, 2'b00, 3'b010, 2'b00, A_NONE, 0, 0));
      cyc(0, OP_NOP, '0, 0, 0, mk(3'd0, 5'b10000, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));

      // the FETCH above was stall #1; 15 more reach the MAX_WAIT boundary, then ERR
      for (int i = 0; i < 15; i++)
         cyc(0, OP_NOP, '0, 0, 0, mk(3'd0, 5'b10000, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));
      for (int i = 0; i < 3; i++)
         cyc(0, OP_NOP, '0, 0, i[0], mk(3'd7, 5'b00000, 2'b00, 3'b000, 2'b00, A_NONE, 0, 1));
      cyc(1, OP_NOP, '0, 0, 0, mk(3'd7, 5'b00000, 2'b00, 3'b000, 2'b00, A_NONE, 0, 1));
      cyc(0, OP_NOP, '0, 0, 1, mk(3'd0, 5'b10010, 2'b00, 3'b000, 2'b00, A_NONE, 0, 0));

      @(negedge clk);
      #1;
      check("sb_drained", 8'(sb.size()), 8'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
